// File: rtl/sevenseg_capture.sv
// Seven-segment loopback monitor: debounces the scanned digit bus, decodes it and
// strobes each complete, error-free 3-digit frame. Optional SEVENSEG_CAPTURE_SEQCHK_EN.
module sevenseg_capture #(
   parameter int unsigned SETTLE_CYCLES  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 540000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  display,
   input  logic [3:0]  digit_select,
   output logic        frame_valid,
   output logic [9:0]  number,
   output logic [11:0] bcd,
   output logic        seg_err,
   output logic        timeout,
   output logic        seq_err
);

   localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 2);
   localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntSettle = CntW'(SETTLE_CYCLES);
   localparam logic [CntW-1:0] CntMax    = CntW'(SETTLE_CYCLES + 1);
   localparam logic [TmrW-1:0] TmrLast   = TmrW'(TIMEOUT_CYCLES - 1);

   localparam logic [0:0] StIdle    = 1'b0;
   localparam logic [0:0] StCollect = 1'b1;

   // Input stage and stability counter
   logic [10:0]     in_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            sel_ok, accept;
   logic [3:0]      dec_val;
   logic            dec_ok;

   always_comb begin
      if ({digit_select, display} != in_q) begin
         cnt_d = CntW'(1);
      end else if (cnt_q != CntMax) begin
         cnt_d = cnt_q + CntW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   assign sel_ok = (in_q[10:7] == 4'b0001) || (in_q[10:7] == 4'b0010) ||
                   (in_q[10:7] == 4'b0100);
   assign accept = (cnt_q == CntSettle) && sel_ok;

   always_comb begin
      dec_ok  = 1'b1;
      dec_val = 4'd0;
      case (in_q[6:0])
         7'b0000001: dec_val = 4'd0;
         7'b1001111: dec_val = 4'd1;
         7'b0010010: dec_val = 4'd2;
         7'b0000110: dec_val = 4'd3;
         7'b1001100: dec_val = 4'd4;
         7'b0100100: dec_val = 4'd5;
         7'b0100000: dec_val = 4'd6;
         7'b0001111: dec_val = 4'd7;
         7'b0000000: dec_val = 4'd8;
         7'b0000100: dec_val = 4'd9;
         default:    dec_ok  = 1'b0;
      endcase
   end

   // Decode stage: one register between accept and frame assembly
   logic       acc_q, acc_ok_q, seg_err_q;
   logic [2:0] acc_slot_q;
   logic [3:0] acc_val_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_q       <= '0;
         cnt_q      <= '0;
         acc_q      <= 1'b0;
         acc_ok_q   <= 1'b0;
         acc_slot_q <= '0;
         acc_val_q  <= '0;
         seg_err_q  <= 1'b0;
      end else begin
         in_q       <= {digit_select, display};
         cnt_q      <= cnt_d;
         acc_q      <= accept;
         acc_ok_q   <= dec_ok;
         acc_slot_q <= in_q[9:7];
         acc_val_q  <= dec_val;
         seg_err_q  <= accept && !dec_ok;
      end
   end

   // Frame assembly
   logic [0:0]      state_q, state_d;
   logic [2:0]      mask_q, mask_d, mask_n;
   logic            bad_q, bad_d, bad_n;
   logic [TmrW-1:0] timer_q, timer_d;
   logic [11:0]     dig_q, dig_d, dig_n;
   logic [9:0]      number_q, number_d, num_calc;
   logic [11:0]     bcd_q, bcd_d;
   logic            fv_q, fv_d, to_q, to_d, expire, take;

   assign expire   = (state_q == StCollect) && (timer_q == TmrLast);
   assign take     = acc_q && !expire;
   assign num_calc = {6'd0, dig_n[11:8]} * 10'd100 + {6'd0, dig_n[7:4]} * 10'd10 +
                     {6'd0, dig_n[3:0]};

   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      bad_d    = bad_q;
      dig_d    = dig_q;
      number_d = number_q;
      bcd_d    = bcd_q;
      fv_d     = 1'b0;
      to_d     = 1'b0;
      timer_d  = (state_q == StCollect) ? timer_q + TmrW'(1) : '0;
      mask_n   = mask_q | acc_slot_q;
      bad_n    = bad_q | !acc_ok_q;
      dig_n    = dig_q;
      if (acc_ok_q) begin
         if (acc_slot_q[0]) dig_n[11:8] = acc_val_q;
         if (acc_slot_q[1]) dig_n[7:4]  = acc_val_q;
         if (acc_slot_q[2]) dig_n[3:0]  = acc_val_q;
      end
      if (expire) begin
         to_d    = 1'b1;
         state_d = StIdle;
         mask_d  = '0;
         bad_d   = 1'b0;
         timer_d = '0;
      end else if (take) begin
         dig_d = dig_n;
         if (mask_n == 3'b111) begin
            if (!bad_n) begin
               fv_d     = 1'b1;
               number_d = num_calc;
               bcd_d    = dig_n;
            end
            state_d = StIdle;
            mask_d  = '0;
            bad_d   = 1'b0;
            timer_d = '0;
         end else begin
            if (state_q == StIdle) timer_d = '0;
            state_d = StCollect;
            mask_d  = mask_n;
            bad_d   = bad_n;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         mask_q   <= '0;
         bad_q    <= 1'b0;
         timer_q  <= '0;
         dig_q    <= '0;
         number_q <= '0;
         bcd_q    <= '0;
         fv_q     <= 1'b0;
         to_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         bad_q    <= bad_d;
         timer_q  <= timer_d;
         dig_q    <= dig_d;
         number_q <= number_d;
         bcd_q    <= bcd_d;
         fv_q     <= fv_d;
         to_q     <= to_d;
      end
   end

`ifdef SEVENSEG_CAPTURE_SEQCHK_EN
   // number_q doubles as the previous good frame value
   logic       have_prev_q, seq_q;
   logic [9:0] num_inc;

   assign num_inc = (number_q == 10'd999) ? 10'd0 : number_q + 10'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         have_prev_q <= 1'b0;
         seq_q       <= 1'b0;
      end else if (fv_d) begin
         have_prev_q <= 1'b1;
         seq_q       <= have_prev_q && (num_calc != number_q) && (num_calc != num_inc);
      end else begin
         seq_q <= 1'b0;
      end
   end

   assign seq_err = seq_q;
`else
   assign seq_err = 1'b0;
`endif

   assign frame_valid = fv_q;
   assign number      = number_q;
   assign bcd         = bcd_q;
   assign seg_err     = seg_err_q;
   assign timeout     = to_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed bench for sevenseg_capture (SETTLE_CYCLES=4, TIMEOUT_CYCLES=100).
module tb_sevenseg_capture;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  display = 7'h7f;
   logic [3:0]  digit_select = 4'b0000;
   logic        frame_valid, seg_err, timeout, seq_err;
   logic [9:0]  number;
   logic [11:0] bcd;

   sevenseg_capture #(
      .SETTLE_CYCLES (4),
      .TIMEOUT_CYCLES(100)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .display     (display),
      .digit_select(digit_select),
      .frame_valid (frame_valid),
      .number      (number),
      .bcd         (bcd),
      .seg_err     (seg_err),
      .timeout     (timeout),
      .seq_err     (seq_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int fv_cnt = 0, se_cnt = 0, to_cnt = 0, sq_cnt = 0, sq_fv_cnt = 0;

   always @(negedge clk) begin
      if (frame_valid) fv_cnt++;
      if (seg_err) se_cnt++;
      if (timeout) to_cnt++;
      if (seq_err) sq_cnt++;
      if (seq_err && frame_valid) sq_fv_cnt++;
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   logic [6:0] seg_tab [10];
   int prev_num = 0;
   bit have_prev = 1'b0;
   int exp_sq = 0;

   // Called at a negedge; holds the digit for n clocks, returning at a negedge.
   task automatic hold(input logic [3:0] sel, input logic [6:0] seg, input int n);
      digit_select = sel;
      display      = seg;
      repeat (n) @(negedge clk);
   endtask

   task automatic run_frame(input int h, input int t, input int o);
      hold(4'b0001, seg_tab[h], 10);
      hold(4'b0010, seg_tab[t], 10);
      hold(4'b0100, seg_tab[o], 10);
   endtask

   task automatic model_good(input int n);
`ifdef SEVENSEG_CAPTURE_SEQCHK_EN
      if (have_prev && !(n == prev_num || n == (prev_num + 1) % 1000)) exp_sq++;
`endif
      prev_num  = n;
      have_prev = 1'b1;
   endtask

   task automatic good_frame(input string tag, input int h, input int t, input int o);
      int fv0;
      fv0 = fv_cnt;
      run_frame(h, t, o);
      model_good(h * 100 + t * 10 + o);
      check_eq({tag, "_fv"}, fv_cnt - fv0, 1);
      check_eq({tag, "_num"}, int'(number), h * 100 + t * 10 + o);
      check_eq({tag, "_bcd"}, int'(bcd), h * 256 + t * 16 + o);
      check_eq({tag, "_seq"}, sq_cnt, exp_sq);
   endtask

   initial begin
      int fv0, se0, to0;
      seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                  7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
      repeat (3) @(negedge clk);
      check_eq("rst_fv", int'(frame_valid), 0);
      check_eq("rst_num", int'(number), 0);
      check_eq("rst_bcd", int'(bcd), 0);
      check_eq("rst_flags", int'({seg_err, timeout, seq_err}), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 123 with exact latency: ones registered on the edge after this negedge
      fv0 = fv_cnt;
      hold(4'b0001, seg_tab[1], 10);
      hold(4'b0010, seg_tab[2], 10);
      hold(4'b0100, seg_tab[3], 5);
      check_eq("lat_early", int'(frame_valid), 0);
      @(negedge clk);
      check_eq("lat_on", int'(frame_valid), 1);
      check_eq("lat_num", int'(number), 123);
      check_eq("lat_bcd", int'(bcd), 12'h123);
      @(negedge clk);
      check_eq("lat_pulse", int'(frame_valid), 0);
      repeat (3) @(negedge clk);
      check_eq("f123_cnt", fv_cnt - fv0, 1);
      model_good(123);

      // Glitchy ones slot must not be accepted until it settles on 9
      fv0 = fv_cnt;
      se0 = se_cnt;
      hold(4'b0001, seg_tab[1], 10);
      hold(4'b0010, seg_tab[2], 10);
      for (int i = 0; i < 5; i++) begin
         hold(4'b0100, seg_tab[3], 2);
         hold(4'b0100, seg_tab[0], 2);
      end
      check_eq("glitch_noacc", fv_cnt - fv0, 0);
      hold(4'b0100, seg_tab[9], 10);
      model_good(129);
      check_eq("glitch_fv", fv_cnt - fv0, 1);
      check_eq("glitch_num", int'(number), 129);
      check_eq("glitch_seg", se_cnt - se0, 0);
      check_eq("glitch_seq", sq_cnt, exp_sq);

      // Undecodable tens pattern poisons the frame
      fv0 = fv_cnt;
      se0 = se_cnt;
      hold(4'b0001, seg_tab[4], 10);
      hold(4'b0010, 7'b1111111, 10);
      hold(4'b0100, seg_tab[5], 10);
      check_eq("bad_seg", se_cnt - se0, 1);
      check_eq("bad_fv", fv_cnt - fv0, 0);
      check_eq("bad_num", int'(number), 129);
      good_frame("f456", 4, 5, 6);

      // Timeout: hundreds and tens only
      fv0 = fv_cnt;
      to0 = to_cnt;
      digit_select = 4'b0001;
      display      = seg_tab[7];
      for (int i = 1; i <= 120; i++) begin
         @(negedge clk);
         if (i == 10) begin
            digit_select = 4'b0010;
            display      = seg_tab[8];
         end
         if (i == 20) begin
            digit_select = 4'b0000;
            display      = 7'h7f;
         end
         if (i == 105) check_eq("to_early", int'(timeout), 0);
         if (i == 106) check_eq("to_on", int'(timeout), 1);
      end
      check_eq("to_cnt", to_cnt - to0, 1);
      check_eq("to_fv", fv_cnt - fv0, 0);
      check_eq("to_num", int'(number), 456);

      // Illegal select: no activity of any kind
      fv0 = fv_cnt;
      se0 = se_cnt;
      to0 = to_cnt;
      hold(4'b0110, seg_tab[1], 50);
      hold(4'b0000, 7'h7f, 150);
      check_eq("sel_quiet", (fv_cnt - fv0) + (se_cnt - se0) + (to_cnt - to0), 0);

      // Mask was cleared by the timeout: a lone ones digit cannot complete a frame
      fv0 = fv_cnt;
      hold(4'b0100, seg_tab[7], 10);
      check_eq("to_cleared", fv_cnt - fv0, 0);
      hold(4'b0001, seg_tab[4], 10);
      hold(4'b0010, seg_tab[5], 10);
      model_good(457);
      check_eq("f457_fv", fv_cnt - fv0, 1);
      check_eq("f457_num", int'(number), 457);

      // Sequence check
      good_frame("f998", 9, 9, 8);
      good_frame("f999", 9, 9, 9);
      good_frame("f000", 0, 0, 0);
      good_frame("f005", 0, 0, 5);
      check_eq("seq_with_fv", sq_fv_cnt, sq_cnt);

      // Reset mid-frame
      hold(4'b0001, seg_tab[1], 10);
      hold(4'b0010, seg_tab[2], 10);
      #2 rst_n = 1'b0;
      #1;
      check_eq("mrst_num", int'(number), 0);
      check_eq("mrst_bcd", int'(bcd), 0);
      check_eq("mrst_flags", int'({frame_valid, seg_err, timeout, seq_err}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      have_prev = 1'b0;
      fv0 = fv_cnt;
      hold(4'b0100, 7'h7f, 2);
      hold(4'b0010, seg_tab[8], 10);
      check_eq("mrst_partial", fv_cnt - fv0, 0);
      check_eq("mrst_keep", int'(number), 0);
      good_frame("f345", 3, 4, 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
